mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit that holds the architectural HI/LO registers.
- Sits beside the ALU in the execute path and takes the same operands: num1 = RD1 (rs), num2 = RD2 (rt).
- Its busy flag drives the CPU stall logic.
- mfhi/mflo results return through hi_out/lo_out into the register write-data mux.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd-family when enabled); legal range 1..15
DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range 1..15

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clears all state
start  input  1  request to issue mdu_op this cycle
mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 reserved
num1  input  32  rs operand
num2  input  32  rt operand
req  input  1  exception/interrupt taken this cycle; suppresses issue
busy  output  1  operation in flight
hi_out  output  32  architectural HI
lo_out  output  32  architectural LO

Behaviour:
- Reset: hi_out=0, lo_out=0, busy=0, counter=0, pending HI/LO=0. Reset mid-operation aborts the operation; HI/LO stay 0.
- Accept condition: start && !busy && !req && op in the legal set. Otherwise the request is dropped with no state change. Reserved ops and op 0 are always ignored.
- mthi/mtlo: on the accept edge, HI<=num1 or LO<=num1. busy stays 0. Results are visible the next cycle.
- mult/multu/div/divu: on the accept edge:
  - compute the result combinationally from num1/num2 and latch it into pending_hi/pending_lo;
  - counter<=N (MULT_CYCLES or DIV_CYCLES).
- busy = (counter != 0). busy rises the cycle after accept and is high for exactly N cycles.
- Counter operation: each edge with counter>1 does counter<=counter-1. At the edge where counter==1: HI<=pending_hi, LO<=pending_lo, counter<=0.
- Visibility: HI/LO update in the same cycle busy falls. mfhi/mflo issued that cycle read the new values.
- mult: 64-bit signed product; HI=[63:32], LO=[31:0].
- multu: same as mult, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (num2==0): the unit still goes busy for DIV_CYCLES. Pending values are loaded from the current HI/LO, so HI/LO are unchanged at completion. No exception is raised.
- start while busy, including mthi/mtlo: ignored. The CPU holds the instruction stalled and re-presents it.
- req while busy does not abort; the in-flight op was already committed.
- req together with start on the accept cycle: no issue, no state change.
- hi_out/lo_out are always the architectural registers, never pending values.

Optional Feature:
MDU_MADD_EN
- Defined: ops 7-10 are legal and take MULT_CYCLES.
  - madd: {HI,LO} <= {HI,LO} + signed(num1*num2).
  - maddu: same as madd, unsigned.
  - msub: {HI,LO} <= {HI,LO} - signed(num1*num2).
  - msubu: same as msub, unsigned.
  - All are modulo 2^64, and {HI,LO} is sampled at the accept edge.
- Undefined: ops 7-10 are treated as reserved and ignored, with no busy and no state change.

Test Plan:
- Signed mult: mult num1=0xFFFFFFFE (-2), num2=3 -> busy high exactly 5 cycles. On the busy-falling cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA. Before that, HI/LO keep their old values.
- Unsigned divide: divu 100/7 -> busy 10 cycles, then LO=14, HI=2.
- Signed divide: div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed-divide overflow: div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: mthi 0x11, mtlo 0x22, then div 5/0 -> busy 10 cycles, HI=0x11, LO=0x22 afterwards.
- Busy/req/reset interactions:
  - mtlo 0xABCD issued while a mult is in flight -> ignored; LO ends as the mult result.
  - start with req=1 -> no busy, HI/LO unchanged.
  - reset asserted in cycle 3 of a div -> busy=0, HI=LO=0 the next cycle.
  - With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1*1 -> HI=1, LO=0.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) enabled by MDU_MADD_EN.
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic        req,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   // Catch illegal latency settings at elaboration
   if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult
      $error("mdu_unit: MULT_CYCLES out of range 1..15");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
      $error("mdu_unit: DIV_CYCLES out of range 1..15");
   end

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] pend_hi_q;
   logic [DATA_W-1:0] pend_lo_q;
   logic [CNT_W-1:0]  count_q;
   logic              busy_q;

   logic              op_legal_c;
   logic              op_mthi_c;
   logic              op_mtlo_c;
   logic              accept_c;
   logic [CNT_W-1:0]  cycles_c;
   logic [DATA_W-1:0] next_hi_c;
   logic [DATA_W-1:0] next_lo_c;

   // Opcode decode: legal set, move-to ops and latency class
   always_comb begin
      op_legal_c = 1'b0;
      op_mthi_c  = 1'b0;
      op_mtlo_c  = 1'b0;
      cycles_c   = CNT_W'(MULT_CYCLES);
      case (mdu_op)
         OP_MULT, OP_MULTU: op_legal_c = 1'b1;
         OP_DIV, OP_DIVU: begin
            op_legal_c = 1'b1;
            cycles_c   = CNT_W'(DIV_CYCLES);
         end
         OP_MTHI: begin
            op_legal_c = 1'b1;
            op_mthi_c  = 1'b1;
         end
         OP_MTLO: begin
            op_legal_c = 1'b1;
            op_mtlo_c  = 1'b1;
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_legal_c = 1'b1;
`endif
         default: op_legal_c = 1'b0;
      endcase
   end

   assign accept_c = start && !busy_q && !req && op_legal_c;

   // Products: low 64 bits of the extended multiply are exact in two's complement
   logic [PROD_W-1:0] prod_s_c;
   logic [PROD_W-1:0] prod_u_c;

   assign prod_s_c = {{DATA_W{num1[DATA_W-1]}}, num1} * {{DATA_W{num2[DATA_W-1]}}, num2};
   assign prod_u_c = {{DATA_W{1'b0}}, num1} * {{DATA_W{1'b0}}, num2};

   // Division on magnitudes; the most-negative dividend needs no special case
   logic              div_zero_c;
   logic [DATA_W-1:0] divisor_u_c;
   logic [DATA_W-1:0] mag1_c;
   logic [DATA_W-1:0] mag2_c;
   logic [DATA_W-1:0] quo_mag_c;
   logic [DATA_W-1:0] rem_mag_c;
   logic [DATA_W-1:0] quo_s_c;
   logic [DATA_W-1:0] rem_s_c;
   logic [DATA_W-1:0] quo_u_c;
   logic [DATA_W-1:0] rem_u_c;

   assign div_zero_c  = (num2 == '0);
   assign divisor_u_c = div_zero_c ? DATA_W'(1) : num2;
   assign mag1_c      = num1[DATA_W-1] ? DATA_W'(~num1 + DATA_W'(1)) : num1;
   assign mag2_c      = num2[DATA_W-1] ? DATA_W'(~num2 + DATA_W'(1)) : divisor_u_c;
   assign quo_mag_c   = mag1_c / mag2_c;
   assign rem_mag_c   = mag1_c % mag2_c;
   assign quo_s_c     = (num1[DATA_W-1] ^ num2[DATA_W-1]) ?
                        DATA_W'(~quo_mag_c + DATA_W'(1)) : quo_mag_c;
   assign rem_s_c     = num1[DATA_W-1] ? DATA_W'(~rem_mag_c + DATA_W'(1)) : rem_mag_c;
   assign quo_u_c     = num1 / divisor_u_c;
   assign rem_u_c     = num1 % divisor_u_c;

`ifdef MDU_MADD_EN
   logic [PROD_W-1:0] acc_c;
   assign acc_c = {hi_q, lo_q};
`endif

   // Result selection latched into the pending registers on accept
   always_comb begin
      next_hi_c = hi_q;
      next_lo_c = lo_q;
      case (mdu_op)
         OP_MULT:  {next_hi_c, next_lo_c} = prod_s_c;
         OP_MULTU: {next_hi_c, next_lo_c} = prod_u_c;
         OP_DIV: begin
            if (!div_zero_c) begin
               next_hi_c = rem_s_c;
               next_lo_c = quo_s_c;
            end
         end
         OP_DIVU: begin
            if (!div_zero_c) begin
               next_hi_c = rem_u_c;
               next_lo_c = quo_u_c;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {next_hi_c, next_lo_c} = PROD_W'(acc_c + prod_s_c);
         OP_MADDU: {next_hi_c, next_lo_c} = PROD_W'(acc_c + prod_u_c);
         OP_MSUB:  {next_hi_c, next_lo_c} = PROD_W'(acc_c - prod_s_c);
         OP_MSUBU: {next_hi_c, next_lo_c} = PROD_W'(acc_c - prod_u_c);
`endif
         default: begin
            next_hi_c = hi_q;
            next_lo_c = lo_q;
         end
      endcase
   end

   // Architectural state, pending results and busy countdown
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
      end else if (count_q != '0) begin
         if (count_q == CNT_W'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            count_q <= '0;
            busy_q  <= 1'b0;
         end else begin
            count_q <= count_q - CNT_W'(1);
         end
      end else if (accept_c) begin
         if (op_mthi_c) begin
            hi_q <= num1;
         end else if (op_mtlo_c) begin
            lo_q <= num1;
         end else begin
            pend_hi_q <= next_hi_c;
            pend_lo_q <= next_lo_c;
            count_q   <= cycles_c;
            busy_q    <= 1'b1;
         end
      end
   end

   assign busy   = busy_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (default latencies 5/10).
// Build with MDU_MADD_EN defined to also exercise the accumulate ops.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] num1;
   logic [31:0] num2;
   logic        req;
   logic        busy;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int checks = 0;
   int errors = 0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdu_op (mdu_op),
      .num1   (num1),
      .num2   (num2),
      .req    (req),
      .busy   (busy),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one request for a single cycle; returns at the negedge after the issue edge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic r);
      @(negedge clk);
      start  = 1'b1;
      mdu_op = op;
      num1   = a;
      num2   = b;
      req    = r;
      @(negedge clk);
      start  = 1'b0;
      req    = 1'b0;
      mdu_op = 4'd0;
   endtask

   // Counts busy-high cycles (already one seen at entry), bounded
   task automatic wait_done(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int n;
      old_hi = hi_out;
      old_lo = lo_out;
      issue(op, a, b, 1'b0);
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      check({tag, "_hi_hold"}, hi_out, old_hi);
      check({tag, "_lo_hold"}, lo_out, old_lo);
      wait_done(n);
      check({tag, "_cycles"}, 32'(n), 32'(cyc));
      check({tag, "_hi"}, hi_out, exp_hi);
      check({tag, "_lo"}, lo_out, exp_lo);
   endtask

   initial begin
      int n;
      reset  = 1'b1;
      start  = 1'b0;
      mdu_op = 4'd0;
      num1   = '0;
      num2   = '0;
      req    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi_out, 32'd0);
      check("reset_lo", lo_out, 32'd0);

      issue(4'd5, 32'h55, 32'h0, 1'b0);
      check("mthi_busy", 32'(busy), 32'd0);
      check("mthi_hi", hi_out, 32'h55);
      issue(4'd6, 32'h66, 32'h0, 1'b0);
      check("mtlo_lo", lo_out, 32'h66);

      run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("divu",  4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
      run_op("div_neg_divisor", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

      issue(4'd5, 32'h11, 32'h0, 1'b0);
      issue(4'd6, 32'h22, 32'h0, 1'b0);
      run_op("div0", 4'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);

      // mtlo presented while a mult is in flight must be dropped
      issue(4'd1, 32'd7, 32'd6, 1'b0);
      start  = 1'b1;
      mdu_op = 4'd6;
      num1   = 32'hABCD;
      repeat (2) @(negedge clk);
      start  = 1'b0;
      mdu_op = 4'd0;
      check("inflight_lo_hold", lo_out, 32'h22);
      wait_done(n);
      check("inflight_cycles", 32'(n), 32'd3);
      check("inflight_hi", hi_out, 32'd0);
      check("inflight_lo", lo_out, 32'd42);

      issue(4'd1, 32'd9, 32'd9, 1'b1);
      check("req_busy", 32'(busy), 32'd0);
      issue(4'd5, 32'h77, 32'h0, 1'b1);
      check("req_hi", hi_out, 32'd0);
      check("req_lo", lo_out, 32'd42);
      issue(4'd11, 32'h77, 32'd1, 1'b0);
      check("reserved_busy", 32'(busy), 32'd0);
`ifndef MDU_MADD_EN
      issue(4'd7, 32'd1, 32'd1, 1'b0);
      check("madd_off_busy", 32'(busy), 32'd0);
      check("madd_off_lo", lo_out, 32'd42);
`endif

      // Reset in the third busy cycle of a divide
      issue(4'd4, 32'd100, 32'd7, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_hi", hi_out, 32'd0);
      check("rst_mid_lo", lo_out, 32'd0);
      repeat (12) @(negedge clk);
      check("rst_mid_lo_later", lo_out, 32'd0);

`ifdef MDU_MADD_EN
      issue(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0);
      run_op("maddu", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0);
      run_op("madd",  4'd7, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);
      run_op("msubu", 4'd10, 32'd2, 32'd3, 5, 32'd0, 32'hFFFF_FFF9);
      run_op("msub",  4'd9, 32'hFFFF_FFFE, 32'd4, 5, 32'd1, 32'h0000_0001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
